// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with 2-entry decode buffer and redirect support
// Optional FETCH_PERF_EN macro adds perf_fetched/perf_redirects/perf_stalls counters.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_rd_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_stalls
`endif
);

    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [31:0]     head_instr, tail_instr;
    logic [XLEN-1:0] head_pc, tail_pc;
    logic [1:0]      count;
    logic            pending;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] fetch_pc;

    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      occupancy;
    logic [XLEN-1:0] target;
    logic            unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    always_comb begin
        pop       = (count != 2'd0) && id_ready;
        push      = pending && !redirect_valid;
        target    = {redirect_pc[XLEN-1:2], 2'b00};
        occupancy = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
        // A redirect always issues: the flush frees every slot this same cycle.
        issue     = !rst && (redirect_valid || (occupancy < 3'd2));
    end

    assign imem_rd_en  = issue;
    assign imem_addr   = rst ? RESET_PC : (redirect_valid ? target : fetch_pc);
    assign id_valid    = (count != 2'd0);
    assign id_instr    = head_instr;
    assign id_pc       = head_pc;
    assign id_pc_plus4 = head_pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_instr <= NOP;
            tail_instr <= NOP;
            head_pc    <= RESET_PC;
            tail_pc    <= RESET_PC;
            count      <= 2'd0;
            pending    <= 1'b0;
            pending_pc <= RESET_PC;
            fetch_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            count      <= 2'd0;
            pending    <= 1'b1;
            pending_pc <= target;
            fetch_pc   <= target + PC_STEP;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= fetch_pc;
                fetch_pc   <= fetch_pc + PC_STEP;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= imem_rdata;
                        tail_pc    <= pending_pc;
                    end else begin
                        head_instr <= imem_rdata;
                        head_pc    <= pending_pc;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= imem_rdata;
                        head_pc    <= pending_pc;
                    end else begin
                        tail_instr <= imem_rdata;
                        tail_pc    <= pending_pc;
                    end
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched   <= 32'd0;
            perf_redirects <= 32'd0;
            perf_stalls    <= 32'd0;
        end else begin
            perf_fetched   <= perf_fetched + 32'(pop);
            perf_redirects <= perf_redirects + 32'(redirect_valid);
            perf_stalls    <= perf_stalls + 32'(id_valid && !id_ready);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed and random phases
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects),
        .perf_stalls    (perf_stalls)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory answers one cycle after each accepted request.
    always @(posedge clk) imem_rdata <= imem_rd_en ? memf(imem_addr) : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Reference stream: decode must see consecutive words from the latest start address.
    logic [31:0] exp_q[$];
    logic [31:0] push_pc = RESET_PC;
    logic        after_redirect = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc, hold_instr;
    int          transfers = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            push_pc        = RESET_PC;
            after_redirect = 1'b0;
            hold_prev      = 1'b0;
        end else begin
            if (after_redirect) check1("valid_after_redirect", id_valid, 1'b0);
            if (hold_prev) begin
                check1("hold_valid", id_valid, 1'b1);
                check32("hold_pc", id_pc, hold_pc);
                check32("hold_instr", id_instr, hold_instr);
            end
            if (id_valid && id_ready) begin
                check32("xfer_pc", id_pc, exp_q[0]);
                check32("xfer_instr", id_instr, memf(exp_q[0]));
                check32("xfer_pc_plus4", id_pc_plus4, exp_q[0] + 32'd4);
                void'(exp_q.pop_front());
                transfers++;
            end
            if (imem_rd_en) check32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (redirect_valid) begin
                exp_q.delete();
                push_pc = {redirect_pc[31:2], 2'b00};
                check1("redirect_rd_en", imem_rd_en, 1'b1);
                check32("redirect_addr", imem_addr, push_pc);
            end
            after_redirect = redirect_valid;
            hold_prev      = id_valid && !id_ready && !redirect_valid;
            hold_pc        = id_pc;
            hold_instr     = id_instr;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(push_pc);
            push_pc = push_pc + 32'd4;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
    endtask

    initial begin
        logic found;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        id_ready       = 1'b1;

        @(negedge clk);
        check1("rst_rd_en", imem_rd_en, 1'b0);
        check32("rst_addr", imem_addr, RESET_PC);
        check1("rst_valid", id_valid, 1'b0);
        check32("rst_instr", id_instr, NOP);
        check32("rst_pc", id_pc, RESET_PC);
        check32("rst_pc_plus4", id_pc_plus4, RESET_PC + 32'd4);

        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("first_valid_latency", id_valid, i == 2);
            if (i == 0) begin
                check1("first_req", imem_rd_en, 1'b1);
                check32("first_addr", imem_addr, RESET_PC);
            end
        end

        // Back-pressure once pc 8 is at the head.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (id_valid && id_pc == 32'd8) found = 1'b1;
            else check1("stream_valid", id_valid, 1'b1);
        end
        check1("wait_pc8", found, 1'b1);
        id_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check1("stall_rd_en", imem_rd_en, 1'b0);
            check1("stall_valid", id_valid, 1'b1);
            check32("stall_pc", id_pc, 32'd8);
        end
        step();
        id_ready = 1'b1;
        repeat (3) @(negedge clk);
        step();
        id_ready = 1'b0;
        repeat (3) step();

        // Redirect while two entries are buffered.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        check32("redir_addr_0x100", imem_addr, 32'h0000_0100);
        step();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        check1("redir_valid_low", id_valid, 1'b0);
        repeat (4) step();

        // Back-to-back redirects: the first target must never surface.
        do_redirect(32'h0000_0040);
        do_redirect(32'h0000_0080);
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (id_valid && id_pc == 32'h0000_0040) found = 1'b1;
        end
        check1("no_0x40", found, 1'b0);
        check32("resume_0x80", id_pc[31:8], 32'd0);

        // Address wrap at the top of the space.
        do_redirect(32'hFFFF_FFFA);
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (id_valid && id_ready && id_pc == 32'd0) found = 1'b1;
        end
        check1("wrap_to_zero", found, 1'b1);

        // Asynchronous reset in the middle of a stream.
        step();
        rst = 1'b1;
        #1;
        check1("async_rst_valid", id_valid, 1'b0);
        check1("async_rst_rd_en", imem_rd_en, 1'b0);
        check32("async_rst_pc", id_pc, RESET_PC);
`ifdef FETCH_PERF_EN
        check32("perf_fetched_rst", perf_fetched, 32'd0);
        check32("perf_redirects_rst", perf_redirects, 32'd0);
        check32("perf_stalls_rst", perf_stalls, 32'd0);
`endif
        step();
        rst = 1'b0;
        @(negedge clk);
        check1("restart_req", imem_rd_en, 1'b1);
        check32("restart_addr", imem_addr, RESET_PC);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst            = 1'b0;
            id_ready       = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 6);
            redirect_pc    = $urandom();
            if ($urandom_range(7) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
            if ($urandom_range(999) < 2) rst = 1'b1;
        end
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        repeat (4) @(negedge clk);
        check1("transfers_min", transfers > 1000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_rd_en  output  1  instruction memory read request.
REQ-006 SHALL have port imem_addr  output  XLEN  byte address of request, bits [1:0] always 0.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid exactly 1 cycle after an accepted request.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect from execute stage.
REQ-009 SHALL have port redirect_pc  input  XLEN  redirect target; bits [1:0] ignored.
REQ-010 SHALL have port id_valid  output  1  instruction presented to decode.
REQ-011 SHALL have port id_ready  input  1  decode accepts; transfer when id_valid && id_ready.
REQ-012 SHALL have ports id_instr (32), id_pc (XLEN), id_pc_plus4 (XLEN)  output  presented instruction, its address, address+4.

Function
REQ-013 SHALL hold a 2-entry FIFO of {instr, pc}; head drives id_* outputs; id_valid = FIFO non-empty.
REQ-014 SHALL track one in-flight flag (pending); responses captured into FIFO the cycle after the request.
REQ-015 SHALL issue a request (imem_rd_en=1, imem_addr=fetch_pc) when count + pending - pop < 2, pop = id_valid && id_ready.
REQ-016 SHALL advance fetch_pc by 4 (modulo 2^XLEN, wrap 0xFFFF_FFFC -> 0) on every issued sequential request.
REQ-017 SHALL sustain one instruction per cycle with id_ready held 1: first id_valid 2 cycles after rst deasserts, then every cycle.
REQ-018 SHALL with id_ready=0 fill to 2 entries then stop requesting; no instruction dropped or duplicated.
REQ-019 SHALL on full FIFO plus simultaneous pop and response, pop head and write response in the same cycle.
REQ-020 SHALL on redirect_valid: flush FIFO, discard the response arriving that cycle, deassert id_valid next cycle, issue request at {redirect_pc[XLEN-1:2],2'b00} in that same cycle, set fetch_pc to target+4.
REQ-021 SHALL give redirect priority over a simultaneous pop; the pop still counts as a completed transfer to decode.
REQ-022 SHALL accept back-to-back redirects; only the last target's stream reaches decode.
REQ-023 SHALL keep id_instr/id_pc/id_pc_plus4 stable while id_valid=1 and id_ready=0.

Reset
REQ-024 SHALL while rst=1 force: imem_rd_en=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC, id_pc_plus4=RESET_PC+4, FIFO empty, pending=0, fetch_pc=RESET_PC.
REQ-025 SHALL on rst asserted mid-operation discard all in-flight and buffered instructions immediately (asynchronously).
REQ-026 SHALL issue the first request at RESET_PC on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL with macro FETCH_PERF_EN defined add outputs perf_fetched (32, count of decode transfers), perf_redirects (32, redirect_valid cycles), perf_stalls (32, cycles with id_valid=1 and id_ready=0), all reset to 0, wrapping at 2^32.
REQ-028 SHALL without FETCH_PERF_EN omit these ports and counters; all other behaviour identical.

Verification
REQ-029 SHALL cover: RESET_PC=0, imem returns addr-indexed words, id_ready=1 -> id_pc 0,4,8,... one per cycle, first id_valid 2 cycles after rst falls.
REQ-030 SHALL cover: id_ready=0 for 5 cycles after pc 8 presented -> exactly 2 entries buffered (8,12), imem_rd_en=0 meanwhile; release -> 8,12,16 in order, none lost.
REQ-031 SHALL cover: redirect_valid with redirect_pc=0x103 while FIFO holds 2 -> imem_addr=0x100 that cycle, id_valid=0 next cycle, then id_pc 0x100,0x104.
REQ-032 SHALL cover: redirects to 0x40 then 0x80 on consecutive cycles -> no id_pc 0x40 ever presented; stream resumes at 0x80.
REQ-033 SHALL cover: rst pulsed mid-stream -> id_valid=0 immediately, restart at RESET_PC; with FETCH_PERF_EN all perf counters read 0.
REQ-034 SHALL cover: fetch_pc at 0xFFFF_FFF8, id_ready=1 -> id_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
